mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative multiply/divide unit that sits beside the single-cycle integer ALU in the execute stage.
- Services mult, multu, div, divu, mthi and mtlo, and holds the architectural HI/LO registers.
- The datapath issues requests with a start pulse, stalls on busy, and samples HI/LO after done.
- Multiply uses shift-add and divide uses restoring division, one bit per cycle.

Parameters:
- WIDTH, 32, operand width; also the iteration count per multiply/divide.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request strobe; sampled on clk rising edge
- Op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 reserved
- A  input  WIDTH  operand rs (dividend / multiplicand / mthi-mtlo source)
- B  input  WIDTH  operand rt (divisor / multiplier)
- busy  output  1  high while an iterative operation is in progress
- done  output  1  one-cycle pulse when HI/LO hold a new mult/div result
- HI  output  WIDTH  high product / remainder
- LO  output  WIDTH  low product / quotient

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, HI=0, LO=0.
  - All internal accumulators are cleared.
  - Applies mid-operation too: the in-flight result is discarded, and no done pulse follows reset release.
- States:
  - IDLE: start=1 with Op 000..011 latches A, B and Op, then goes to CALC with counter=0. start with Op 100/101 writes HI or LO at that edge, stays in IDLE, and asserts no busy and no done. Reserved Ops are ignored.
  - CALC: one iteration per edge. counter counts 0..WIDTH-1. After the edge with counter=WIDTH-1, go to FIX.
  - FIX: applies sign correction and writes HI/LO. done=1 is registered for the next cycle. Returns to IDLE.
- Timing:
  - Start accepted at edge 0.
  - busy is high from after edge 0 through edge WIDTH+1, i.e. WIDTH+1 cycles (33 at default).
  - HI/LO are updated and done=1 in the cycle following edge WIDTH+1.
  - done lasts exactly one cycle.
- start while busy=1 is ignored for every Op, including mthi/mtlo. Operands must be held by the caller only on the start cycle.
- start in the same cycle done=1 is accepted normally, giving back-to-back operations. The new operation does not disturb the HI/LO values just written until its own FIX.
- Signed ops (mult, div):
  - Operate on magnitudes.
  - Product is negated if signs differ.
  - Quotient is negated if signs differ.
  - Remainder takes the sign of the dividend.
- Unsigned ops: operands are treated as unsigned, with no correction.
- Multiply: {HI,LO} = full 2*WIDTH product, no overflow.
- Divide by zero (div and divu): LO=all ones, HI=A; completes with normal latency.
- Signed overflow (div, A=0x80000000, B=0xFFFFFFFF): LO=0x80000000, HI=0.
- HI/LO change only at reset, FIX, or an accepted mthi/mtlo.

Test Plan:
- Reset: assert rst_n=0 mid-CALC of mult 7*6 → busy=0, HI=0, LO=0 immediately. After release: no done, and IDLE accepts a new start.
- mult A=0xFFFFFFFE (-2), B=3 → busy for 33 cycles, then done pulse with HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div A=-7 (0xFFFFFFF9), B=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu A=100, B=7 → LO=14, HI=2.
- Boundaries:
  - divu A=5, B=0 → LO=0xFFFFFFFF, HI=5.
  - div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
  - Both take normal latency with no hang.
- Handshake:
  - mthi A=0x1234 while idle → HI=0x1234 next cycle, busy and done stay 0.
  - mtlo and a second mult issued while busy → ignored; HI/LO reflect only the first op.
  - New start on the done cycle → accepted, busy re-asserts next cycle.

Source files
------------

// File: rtl/mdu_iter.sv
// Purpose : iterative mult/multu/div/divu unit with architectural HI/LO and mthi/mtlo writes.
// Latency : busy for WIDTH+1 cycles after the start edge; done pulses with new HI/LO one cycle later.
// Backpr. : start is dropped for every Op while busy; mthi/mtlo complete in one edge when idle.
module mdu_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [CW-1:0]    cnt;
   logic             is_div_q;   // latched op class: 1 = divide, 0 = multiply
   logic             neg_q;      // negate product / quotient in FIX
   logic             neg_r;      // negate remainder in FIX (dividend was negative)
   logic             div0_q;     // divisor was zero
   logic [WIDTH-1:0] a_q;        // raw dividend, returned in HI on divide by zero
   logic [WIDTH-1:0] opnd_q;     // multiplicand or divisor magnitude
   logic [WIDTH-1:0] acc_hi;     // partial product high half / partial remainder
   logic [WIDTH-1:0] acc_lo;     // multiplier shifting out / dividend shifting out, quotient shifting in

   // Request decode: only Op 0xx starts an iteration, 100/101 are register moves.
   logic accept_calc, accept_move;
   assign accept_calc = start && (state == S_IDLE) && !Op[2];
   assign accept_move = start && (state == S_IDLE) && Op[2] && !Op[1];

   // Signed ops (Op[0]==0) work on magnitudes; the most negative value maps onto itself as unsigned.
   logic             op_signed, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   assign op_signed = !Op[0];
   assign a_neg     = op_signed && A[WIDTH-1];
   assign b_neg     = op_signed && B[WIDTH-1];
   assign a_mag     = a_neg ? -A : A;
   assign b_mag     = b_neg ? -B : B;

   // Shift-add step: add multiplicand when the current multiplier bit is set, then shift right.
   logic [WIDTH:0] mul_sum;
   assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);

   // Restoring-division step: bring in the next dividend bit, subtract when it fits.
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_sub;
   assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
   assign div_ge    = div_shift >= {1'b0, opnd_q};
   assign div_sub   = div_shift[WIDTH-1:0] - opnd_q;  // only used when it fits, so the top bit is zero

   // Sign correction applied on the way into HI/LO.
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   assign prod     = {acc_hi, acc_lo};
   assign prod_fix = neg_q ? -prod : prod;
   assign quo_fix  = neg_q ? -acc_lo : acc_lo;
   assign rem_fix  = neg_r ? -acc_hi : acc_hi;

   assign busy = (state != S_IDLE);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: IDLE -> CALC for WIDTH edges -> FIX for one edge -> IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept_calc) state_nxt = S_CALC;
         S_CALC:  if (cnt == CNT_LAST) state_nxt = S_FIX;
         S_FIX:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand capture and one iteration per CALC edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div0_q   <= 1'b0;
         a_q      <= '0;
         opnd_q   <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
      end else if (accept_calc) begin
         cnt      <= '0;
         is_div_q <= Op[1];
         neg_q    <= a_neg ^ b_neg;
         neg_r    <= a_neg;
         div0_q   <= (B == '0);
         a_q      <= A;
         acc_hi   <= '0;
         if (Op[1]) begin
            acc_lo <= a_mag;
            opnd_q <= b_mag;
         end else begin
            acc_lo <= b_mag;
            opnd_q <= a_mag;
         end
      end else if (state == S_CALC) begin
         cnt <= cnt + 1'b1;
         if (!is_div_q) begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
         end else begin
            acc_hi <= div_ge ? div_sub : div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
         end
      end
   end

   // Architectural HI/LO: written only by FIX or an idle mthi/mtlo; done marks a FIX write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done <= 1'b0;
         HI   <= '0;
         LO   <= '0;
      end else begin
         done <= (state == S_FIX);
         if (state == S_FIX) begin
            if (!is_div_q) begin
               {HI, LO} <= prod_fix;
            end else if (div0_q) begin
               HI <= a_q;
               LO <= '1;
            end else begin
               HI <= rem_fix;
               LO <= quo_fix;
            end
         end else if (accept_move) begin
            if (Op[0]) LO <= A;
            else       HI <= A;
         end
      end
   end

endmodule

// File: tb/tb_mdu_iter.sv
// Purpose : self-checking bench for mdu_iter with a queue scoreboard and an arithmetic reference model.
// Latency : expects WIDTH+1 busy cycles per mult/div and a one-cycle done pulse.
// Backpr. : drives start only on the falling edge; ignored requests push no expectation.
module tb_mdu_iter;

   localparam int W   = 32;
   localparam int LAT = W + 1;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [2:0]    Op;
   logic [W-1:0]  A, B;
   logic          busy, done;
   logic [W-1:0]  HI, LO;

   mdu_iter #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .Op    (Op),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .HI    (HI),
      .LO    (LO)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int           tests = 0;
   int           fails = 0;
   logic [63:0]  exp_q[$];
   logic [31:0]  hi_m = '0;
   logic [31:0]  lo_m = '0;
   logic         done_d = 1'b0;
   logic [63:0]  mon_e;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
      end
   endtask

   // Reference model: {HI,LO} from plain 64-bit arithmetic.
   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] res;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      res = '0;
      case (op)
         3'd0: res = sa * sb;
         3'd1: res = {32'b0, a} * {32'b0, b};
         3'd2: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else begin
               q   = sa / sb;
               r   = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         3'd3: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else        res = {a % b, a / b};
         end
         default: res = '0;
      endcase
      return res;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst_n) begin
         done_d = 1'b0;
      end else begin
         if (done) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_done: got HI=0x%08h LO=0x%08h with nothing outstanding", HI, LO);
            end else begin
               mon_e = exp_q.pop_front();
               check("result_hi", HI, mon_e[63:32]);
               check("result_lo", LO, mon_e[31:0]);
               hi_m = mon_e[63:32];
               lo_m = mon_e[31:0];
            end
            if (done_d) begin
               tests++;
               fails++;
               $display("FAIL done_width: got done high two cycles in a row want one");
            end
         end
         done_d = done;
      end
   end

   // Present a request for one cycle starting at the current falling edge.
   task automatic drive_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
      start = 1'b1;
      Op    = op;
      A     = a;
      B     = b;
      if (push) exp_q.push_back(model(op, a, b));
      @(negedge clk);
      start = 1'b0;
      A     = $urandom;
      B     = $urandom;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      drive_start(op, a, b, 1'b1);
   endtask

   // Count busy cycles until done, bounded so a stuck unit still reaches the summary.
   task automatic wait_done(input int exp_busy, input string nm);
      int cnt = 0;
      int n   = 0;
      while (!done && n < 200) begin
         if (busy) cnt++;
         @(negedge clk);
         n++;
      end
      check({nm, "_busy_cycles"}, 32'(cnt), 32'(exp_busy));
      check({nm, "_done_seen"}, {31'b0, done}, 32'd1);
   endtask

   // Register move while idle: visible next cycle, no busy or done.
   task automatic move(input bit to_lo, input logic [31:0] v);
      @(negedge clk);
      drive_start(to_lo ? 3'd5 : 3'd4, v, $urandom, 1'b0);
      if (to_lo) lo_m = v;
      else       hi_m = v;
      check("move_hi", HI, hi_m);
      check("move_lo", LO, lo_m);
      check("move_busy", {31'b0, busy}, 32'd0);
      check("move_done", {31'b0, done}, 32'd0);
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      bit saw_done;
      rst_n = 1'b0;
      start = 1'b0;
      Op    = 3'd0;
      A     = '0;
      B     = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_done", {31'b0, done}, 32'd0);
      check("reset_hi", HI, 32'd0);
      check("reset_lo", LO, 32'd0);
      rst_n = 1'b1;

      // Make HI/LO non-zero, then reset in the middle of a multiply.
      move(1'b0, 32'h0000_0055);
      move(1'b1, 32'h0000_0066);
      @(negedge clk);
      drive_start(3'd0, 32'd7, 32'd6, 1'b0);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", {31'b0, busy}, 32'd0);
      check("midrst_hi", HI, 32'd0);
      check("midrst_lo", LO, 32'd0);
      hi_m = '0;
      lo_m = '0;
      @(negedge clk);
      rst_n = 1'b1;
      saw_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      check("midrst_no_done", {31'b0, saw_done}, 32'd0);
      issue(3'd0, 32'd7, 32'd6);
      wait_done(LAT, "post_rst_mult");

      // Directed arithmetic and boundaries.
      issue(3'd0, 32'hFFFF_FFFE, 32'd3);  wait_done(LAT, "mult_neg");
      issue(3'd1, 32'hFFFF_FFFE, 32'd3);  wait_done(LAT, "multu");
      issue(3'd2, 32'hFFFF_FFF9, 32'd2);  wait_done(LAT, "div_neg");
      issue(3'd3, 32'd100, 32'd7);        wait_done(LAT, "divu");
      issue(3'd3, 32'd5, 32'd0);          wait_done(LAT, "divu_by0");
      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF); wait_done(LAT, "div_ovf");

      move(1'b0, 32'h0000_1234);

      // Requests while busy are ignored, including register moves.
      issue(3'd0, 32'd1000, 32'hFFFF_FFF0);
      repeat (5) @(negedge clk);
      drive_start(3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);
      drive_start(3'd0, 32'd9, 32'd9, 1'b0);
      check("busy_ign_hi", HI, hi_m);
      check("busy_ign_lo", LO, lo_m);
      wait_done(LAT - 7, "busy_ign");

      // Back-to-back: start on the done cycle; HI/LO hold until the second FIX.
      issue(3'd3, 32'd12345, 32'd17);
      wait_done(LAT, "b2b_first");
      drive_start(3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
      check("b2b_busy", {31'b0, busy}, 32'd1);
      repeat (4) @(negedge clk);
      check("b2b_hold_hi", HI, hi_m);
      check("b2b_hold_lo", LO, lo_m);
      wait_done(LAT - 4, "b2b_second");

      // Randomized mix of operations.
      for (int i = 0; i < 30; i++) begin
         int          sel;
         logic [31:0] ra, rb;
         sel = $urandom_range(0, 5);
         ra  = rnd_operand();
         rb  = rnd_operand();
         if (sel >= 4) begin
            move(sel == 5, ra);
         end else begin
            issue(3'(sel), ra, rb);
            wait_done(LAT, "rand");
         end
      end

      // Reserved opcodes do nothing.
      @(negedge clk);
      drive_start(3'd6, 32'hAAAA_AAAA, 32'd1, 1'b0);
      drive_start(3'd7, 32'h5555_5555, 32'd1, 1'b0);
      check("reserved_busy", {31'b0, busy}, 32'd0);
      check("reserved_hi", HI, hi_m);
      check("reserved_lo", LO, lo_m);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
